nts_rx_buffer_pingpong: RTL and testbench

//  Two-bank (ping-pong) RX packet buffer between the dispatcher FIFO and the NTS parser.

---
 rtl/nts_rx_buffer_pingpong.sv | 239 +++++++++++++++++++++++
 tb/tb_nts_rx_buffer_pingpong.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_rx_buffer_pingpong.sv
// Purpose : two-bank ping-pong RX packet buffer between dispatcher FIFO and NTS parser.
// Latency : access-port read 3 cycles (word-local) or 4 cycles (word-crossing), rd_en -> rd_dv.
// Backpr. : o_dispatch_ready low while both banks hold packets; writes then are dropped and flagged.
//
// Ports:
//   i_clk, i_areset            clock / synchronous active-high reset
//   i_clear                    parser done with current read bank
//   i_dispatch_fifo_rd_*       64-bit word write strobe, data (byte 0 = bits 63:56), last flag
//   o_dispatch_ready/_dropped  write bank free / 1-cycle drop pulse
//   o_packet_available/_words  read bank holds a packet / its word count
//   i_access_port_*            byte address, size code (0=1B 1=2B 2=4B 3+=8B), read start
//   o_access_port_*            busy, data-valid pulse, right-justified data
// Optional feature macro: NTS_RX_BUFFER_BOUNDS_CHECK_EN adds o_access_port_error and zeroes
// data for reads reaching past the stored packet.

module nts_rx_buffer_pingpong #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_clear,
  input  logic                  i_dispatch_fifo_rd_en,
  input  logic [63:0]           i_dispatch_fifo_rd_data,
  input  logic                  i_dispatch_fifo_rd_last,
  output logic                  o_dispatch_ready,
  output logic                  o_dispatch_dropped,
  output logic                  o_packet_available,
  output logic [ADDR_WIDTH:0]   o_packet_words,
  output logic                  o_access_port_wait,
  input  logic [ADDR_WIDTH+2:0] i_access_port_addr,
  input  logic [2:0]            i_access_port_wordsize,
  input  logic                  i_access_port_rd_en,
  output logic                  o_access_port_rd_dv,
`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
  output logic                  o_access_port_error,
`endif
  output logic [63:0]           o_access_port_rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH0 = 2'd1,
    S_FETCH1 = 2'd2,
    S_ALIGN  = 2'd3
  } state_t;

  // Both banks live in one array; the bank select is the top address bit.
  logic [63:0]           r_mem [0:2*DEPTH-1];

  logic [1:0]            r_full;
  logic [ADDR_WIDTH:0]   r_len [0:1];
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic                  r_dropped;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH+2:0] r_addr;
  logic [1:0]            r_size;
  logic [63:0]           r_word0;
  logic [63:0]           r_word1;
  logic [63:0]           r_rd_data;
  logic                  r_dv;

  logic                  w_ready;
  logic                  w_wr_room;
  logic                  w_wr_accept;
  logic                  w_wr_store;
  logic                  w_wr_end;
  logic                  w_clr_bank;

  logic [2:0]            w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_word1;
  logic [3:0]            w_bytes;
  logic                  w_cross;
  logic [127:0]          w_cat;
  logic [6:0]            w_msb;
  logic [63:0]           w_top;
  logic [63:0]           w_align;
  logic                  w_start;
  logic                  w_dv_set;
  logic                  w_oob;

  // ---------------------------------------------------------------- write side
  // The write bank is never the full bank unless both are full, so its own
  // flag is the ready indication.
  assign w_ready     = ~r_full[r_wr_bank];
  assign w_wr_room   = (r_wr_ptr != LP_DEPTH);
  assign w_wr_accept = i_dispatch_fifo_rd_en & w_ready;
  assign w_wr_store  = w_wr_accept & w_wr_room;
  assign w_wr_end    = w_wr_accept & i_dispatch_fifo_rd_last;
  // A full read bank can never be the bank receiving the last word, so clear
  // and packet completion in one cycle touch different flags.
  assign w_clr_bank  = i_clear & r_full[r_rd_bank];

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_full    <= 2'b00;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= i_dispatch_fifo_rd_en & (~w_ready | ~w_wr_room);
      if (w_wr_end) begin
        r_full[r_wr_bank] <= 1'b1;
        // A saturated packet keeps the DEPTH words it managed to store.
        r_len[r_wr_bank]  <= w_wr_room ? (r_wr_ptr + 1'b1) : r_wr_ptr;
        r_wr_ptr          <= '0;
        r_wr_bank         <= ~r_wr_bank;
      end else if (w_wr_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_clr_bank) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  // RAM: write port from the dispatcher, registered read port for the FSM.
  always_ff @(posedge i_clk) begin
    if (w_wr_store) begin
      r_mem[{r_wr_bank, r_wr_ptr[ADDR_WIDTH-1:0]}] <= i_dispatch_fifo_rd_data;
    end
    if (r_state == S_FETCH0) begin
      r_word0 <= r_mem[{r_rd_bank, w_word}];
    end
    if (r_state == S_FETCH1) begin
      r_word1 <= r_mem[{r_rd_bank, w_word1}];
    end
  end

  assign o_dispatch_ready   = w_ready;
  assign o_dispatch_dropped = r_dropped;
  assign o_packet_available = r_full[r_rd_bank];
  assign o_packet_words     = r_len[r_rd_bank];

  // ----------------------------------------------------------------- read side
  assign w_offset = r_addr[2:0];
  assign w_word   = r_addr[ADDR_WIDTH+2:3];
  assign w_word1  = w_word + 1'b1;   // wraps within the bank

  always_comb begin
    w_bytes = 4'd8;
    case (r_size)
      2'd0:    w_bytes = 4'd1;
      2'd1:    w_bytes = 4'd2;
      2'd2:    w_bytes = 4'd4;
      default: w_bytes = 4'd8;
    endcase
  end

  assign w_cross = (({1'b0, w_offset}) + w_bytes) > 4'd8;

  // Window of 8 bytes starting at the byte offset; when the access does not
  // cross, only bytes of word0 are ever selected, so a stale word1 is harmless.
  assign w_cat = {r_word0, r_word1};
  assign w_msb = 7'd127 - {1'b0, w_offset, 3'b000};
  assign w_top = w_cat[w_msb -: 64];

  always_comb begin
    w_align = w_top;
    case (r_size)
      2'd0:    w_align = {56'd0, w_top[63:56]};
      2'd1:    w_align = {48'd0, w_top[63:48]};
      2'd2:    w_align = {32'd0, w_top[63:32]};
      default: w_align = w_top;
    endcase
  end

`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
  logic [ADDR_WIDTH+3:0] w_last_byte;
  logic                  r_err;
  assign w_last_byte = {1'b0, r_addr} + {{ADDR_WIDTH{1'b0}}, w_bytes} - 1'b1;
  assign w_oob       = ~r_full[r_rd_bank] | (w_last_byte >= {r_len[r_rd_bank], 3'b000});
  assign o_access_port_error = r_err;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_dv_set & w_oob;
    end
  end
`else
  assign w_oob = 1'b0;
`endif

  assign w_start  = i_access_port_rd_en & ~i_clear;
  assign w_dv_set = (r_state == S_ALIGN) & ~i_clear;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_FETCH0;
      S_FETCH0: w_next = w_cross ? S_FETCH1 : S_ALIGN;
      S_FETCH1: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    // Parser abandons the packet: drop any read in flight.
    if (i_clear) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_size    <= 2'd0;
      r_rd_data <= '0;
      r_dv      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dv    <= w_dv_set;
      if ((r_state == S_IDLE) && w_start) begin
        r_addr <= i_access_port_addr;
        r_size <= i_access_port_wordsize[2] ? 2'd3 : i_access_port_wordsize[1:0];
      end
      if (w_dv_set) begin
        r_rd_data <= w_oob ? 64'd0 : w_align;
      end
    end
  end

  assign o_access_port_wait    = (r_state != S_IDLE);
  assign o_access_port_rd_dv   = r_dv;
  assign o_access_port_rd_data = r_rd_data;

endmodule

// File: tb/tb_nts_rx_buffer_pingpong.sv
module tb_nts_rx_buffer_pingpong;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          areset;
  logic          clear;
  logic          wr_en;
  logic [63:0]   wr_data;
  logic          wr_last;
  logic          ready;
  logic          dropped;
  logic          avail;
  logic [AW:0]   words;
  logic          apwait;
  logic [AW+2:0] rd_addr;
  logic [2:0]    rd_ws;
  logic          rd_en;
  logic          dv;
  logic [63:0]   rd_data;
`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
  logic          ap_err;
`endif

  nts_rx_buffer_pingpong #(.ADDR_WIDTH(AW)) dut (
    .i_clk                   (clk),
    .i_areset                (areset),
    .i_clear                 (clear),
    .i_dispatch_fifo_rd_en   (wr_en),
    .i_dispatch_fifo_rd_data (wr_data),
    .i_dispatch_fifo_rd_last (wr_last),
    .o_dispatch_ready        (ready),
    .o_dispatch_dropped      (dropped),
    .o_packet_available      (avail),
    .o_packet_words          (words),
    .o_access_port_wait      (apwait),
    .i_access_port_addr      (rd_addr),
    .i_access_port_wordsize  (rd_ws),
    .i_access_port_rd_en     (rd_en),
    .o_access_port_rd_dv     (dv),
`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
    .o_access_port_error     (ap_err),
`endif
    .o_access_port_rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  localparam logic [63:0] W0 = 64'hdeadbeef00000000;
  localparam logic [63:0] W1 = 64'habad1deac0fef00d;
  localparam logic [63:0] W2 = 64'h0123456789abcdef;
  localparam logic [63:0] PA = 64'haaaa000011112222;
  localparam logic [63:0] PB = 64'hbbbb333344445555;
  localparam logic [63:0] PC = 64'hcccc666677778888;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every data-valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (dv === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dv: got dv=1 data %h, expected no dv", rd_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_latency", 64'(cyc - e.issue), 64'(e.lat));
        check("wait_at_dv", {63'd0, apwait}, 64'd0);
`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
        check("rd_error", {63'd0, ap_err}, {63'd0, e.err});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [63:0] d, input logic last, output logic drp);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
    drp     = dropped;
  endtask

  task automatic do_read(input logic [AW+2:0] a, input logic [2:0] ws,
                         input logic [63:0] exp, input logic err, input int lat);
    exp_t e;
    e.data  = exp;
    e.err   = err;
    e.lat   = lat;
    e.issue = cyc;
    sb_q.push_back(e);
    rd_addr = a;
    rd_ws   = ws;
    rd_en   = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 8 && dv !== 1'b1; i++) tick();
    if (dv !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no dv for addr %h, expected dv within 8 cycles", a);
      sb_q.delete();
    end
    tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic drp;
    int   ndrop;

    areset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0;
    rd_addr = '0; rd_ws = '0; rd_en = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    // Reset state
    check("rst_ready",   {63'd0, ready},   64'd1);
    check("rst_dropped", {63'd0, dropped}, 64'd0);
    check("rst_avail",   {63'd0, avail},   64'd0);
    check("rst_words",   64'(words),       64'd0);
    check("rst_wait",    {63'd0, apwait},  64'd0);
    check("rst_rd_data", rd_data,          64'd0);

    // 1: three-word packet, aligned read
    write_word(W0, 1'b0, drp);
    write_word(W1, 1'b0, drp);
    write_word(W2, 1'b1, drp);
    check("t1_drop",  {63'd0, drp},   64'd0);
    check("t1_avail", {63'd0, avail}, 64'd1);
    check("t1_words", 64'(words),     64'd3);
    do_read(11'h000, 3'd3, 64'hdeadbeef00000000, 1'b0, 3);

    // 2: unaligned / crossing reads, oversize code treated as 8 bytes
    do_read(11'h001, 3'd3, 64'hadbeef00000000ab, 1'b0, 4);
    do_read(11'h00F, 3'd3, 64'h0d0123456789abcd, 1'b0, 4);
    do_read(11'h017, 3'd0, 64'h00000000000000ef, 1'b0, 3);
    do_read(11'h00F, 3'd1, 64'h0000000000000d01, 1'b0, 4);
    do_read(11'h00D, 3'd2, 64'h00000000fef00d01, 1'b0, 4);
    do_read(11'h000, 3'd5, 64'hdeadbeef00000000, 1'b0, 3);

    // 3: both banks full -> backpressure and drop; clear frees one bank
    pulse_clear();
    check("t3_avail_after_clr", {63'd0, avail}, 64'd0);
    write_word(PA, 1'b1, drp);
    write_word(PB, 1'b1, drp);
    check("t3_ready_full", {63'd0, ready}, 64'd0);
    check("t3_avail",      {63'd0, avail}, 64'd1);
    check("t3_words",      64'(words),     64'd1);
    write_word(PC, 1'b0, drp);
    check("t3_drop", {63'd0, drp}, 64'd1);
    do_read(11'h000, 3'd3, PA, 1'b0, 3);
    pulse_clear();
    check("t3_ready_freed", {63'd0, ready}, 64'd1);
    do_read(11'h000, 3'd3, PB, 1'b0, 3);

    // 4: clear aborts a read in flight
    rd_addr = 11'h000; rd_ws = 3'd3; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t4_wait_busy", {63'd0, apwait}, 64'd1);
    pulse_clear();
    check("t4_wait_abort", {63'd0, apwait}, 64'd0);
    repeat (5) tick();
    check("t4_data_held", rd_data, PB);
    check("t4_avail", {63'd0, avail}, 64'd0);
    do_read(11'h000, 3'd3, PA, 1'b0, 3);

    // 5: overflow saturates at DEPTH, wrap-around read
    ndrop = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      write_word(64'h1000000000000000 + 64'(i), 1'b0, drp);
      if (drp) ndrop++;
    end
    write_word(64'h2000000000000000, 1'b1, drp);
    if (drp) ndrop++;
    check("t5_drops", 64'(ndrop),     64'd3);
    check("t5_avail", {63'd0, avail}, 64'd1);
    check("t5_words", 64'(words),     64'(DEPTH));
    check("t5_ready", {63'd0, ready}, 64'd1);
    do_read(11'h7FF, 3'd1, 64'h000000000000ff10, 1'b0, 4);
    do_read(11'h7F8, 3'd3, 64'h10000000000000ff, 1'b0, 3);
    do_read(11'h000, 3'd3, 64'h1000000000000000, 1'b0, 3);

    // 6: three-word packet for the bounds check
    write_word(W0, 1'b0, drp);
    write_word(W1, 1'b0, drp);
    write_word(W2, 1'b1, drp);
    pulse_clear();
    check("t6_words", 64'(words), 64'd3);
`ifdef NTS_RX_BUFFER_BOUNDS_CHECK_EN
    do_read(11'h015, 3'd3, 64'd0, 1'b1, 4);
`endif
    do_read(11'h010, 3'd3, W2, 1'b0, 3);

    // 7: reset in the middle of a read
    rd_addr = 11'h001; rd_ws = 3'd3; rd_en = 1'b1;
    tick();
    rd_en  = 1'b0;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check("t7_wait",    {63'd0, apwait}, 64'd0);
    check("t7_rd_data", rd_data,         64'd0);
    check("t7_avail",   {63'd0, avail},  64'd0);
    check("t7_ready",   {63'd0, ready},  64'd1);
    repeat (6) tick();

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
